ex3_digit_sequencer: RTL

EX3_DIGIT_SEQUENCER -- requirements
Module: ex3_digit_sequencer

---
 rtl/ex3_digit_sequencer.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/ex3_digit_sequencer.sv
// ---------------------------------------------------------------------------
// ex3_digit_sequencer
//
// Collects NUM_DIGITS Excess-3 coded decimal digits, most significant digit
// first, and converts the frame to a binary value. Each accepted digit
// updates acc <= acc*10 + (digit-3). After the last digit of a frame the
// result is parked in a HOLD state until the consumer takes it.
//
// Optional feature: define EX3_ERR_CHECK_EN to flag invalid Excess-3 codes
// (0000-0010, 1101-1111). An invalid digit contributes 0 to the value and
// sets a sticky frame error reported on out_err. Without the macro, out_err
// is tied to 0 and every code is decoded as (code - 3) mod 16.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   in_digit holds a digit
//   in_ready   out  a digit is accepted this cycle when in_valid is also 1
//   in_digit   in   4-bit Excess-3 digit
//   out_valid  out  out_bin / out_err hold a completed frame
//   out_ready  in   consumer takes the result
//   out_bin    out  binary value of the frame (OUT_W bits)
//   out_err    out  frame contained an invalid code
//   busy       out  digits of the current frame accepted, or result held
//   dbg_state  out  current FSM state (0 = ACCUM, 1 = HOLD)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1; valid may not depend on ready, and the data is only meaningful
// while valid is 1. in_ready is 1 exactly in ACCUM, out_valid exactly in
// HOLD, so the block never accepts a digit while a result is pending.
// ---------------------------------------------------------------------------
module ex3_digit_sequencer #(
  parameter int NUM_DIGITS = 4,
  parameter int OUT_W      = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_digit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_bin,
  output logic             out_err,
  output logic             busy,
  output logic             dbg_state
);

  // One extra bit so the counter can hold NUM_DIGITS itself while in HOLD.
  localparam int CW = $clog2(NUM_DIGITS) + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_DIGITS - 1);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic [OUT_W-1:0] out_bin_q, out_bin_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             accept;
  logic [3:0]       dec;
  logic [OUT_W-1:0] acc_next;

`ifdef EX3_ERR_CHECK_EN
  logic             err_q, err_d;
  logic             out_err_q, out_err_d;
  logic             dig_bad;

  // Valid Excess-3 codes are 0011..1100; anything else decodes to 0.
  always_comb begin
    dig_bad = (in_digit < 4'd3) || (in_digit > 4'd12);
    dec     = dig_bad ? 4'd0 : (in_digit - 4'd3);
  end
`else
  // Without checking, wrap modulo 16 (e.g. 0000 decodes to 13).
  always_comb begin
    dec = in_digit - 4'd3;
  end
`endif

  assign accept = in_valid && (state_q == ACCUM);

  // Arithmetic in OUT_W bits: the low bits of a product/sum do not depend
  // on the discarded high bits, so this is the truncated result directly.
  assign acc_next = (acc_q * OUT_W'(10)) + OUT_W'(dec);

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    out_bin_d = out_bin_q;
`ifdef EX3_ERR_CHECK_EN
    err_d     = err_q;
    out_err_d = out_err_q;
`endif
    case (state_q)
      ACCUM: begin
        if (accept) begin
          acc_d = acc_next;
          cnt_d = cnt_q + CW'(1);
`ifdef EX3_ERR_CHECK_EN
          err_d = err_q | dig_bad;
`endif
          if (cnt_q == LAST_IDX) begin
            out_bin_d = acc_next;
`ifdef EX3_ERR_CHECK_EN
            out_err_d = err_q | dig_bad;
`endif
            state_d   = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = ACCUM;
          acc_d   = '0;
          cnt_d   = '0;
`ifdef EX3_ERR_CHECK_EN
          err_d   = 1'b0;
`endif
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ACCUM;
      acc_q     <= '0;
      cnt_q     <= '0;
      out_bin_q <= '0;
`ifdef EX3_ERR_CHECK_EN
      err_q     <= 1'b0;
      out_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      out_bin_q <= out_bin_d;
`ifdef EX3_ERR_CHECK_EN
      err_q     <= err_d;
      out_err_q <= out_err_d;
`endif
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign out_bin   = out_bin_q;
  assign busy      = (cnt_q != '0) || (state_q == HOLD);
  assign dbg_state = state_q;
`ifdef EX3_ERR_CHECK_EN
  assign out_err   = out_err_q;
`else
  assign out_err   = 1'b0;
`endif

endmodule
